// File: rtl/not_pipe_if.sv
// Stream bundle for not_pipe: upstream word/mode/mask channel and downstream result channel.
// slave is the pipeline's view, master is the driving environment's view.
interface not_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic [WIDTH-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_mode, in_mask, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_mode, in_mask, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/not_pipe.sv
// Elastic DEPTH-stage pipeline applying pass / invert / masked-invert to WIDTH-bit words.
// Define NOT_PIPE_XFER_CNT_EN to build the 16-bit output-handshake counter; otherwise xfer_cnt is 0.
module not_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  not_pipe_if.slave   bus,
  output logic [15:0] xfer_cnt
);

  logic [DEPTH-1:0] stage_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] advance;
  logic [DEPTH:0]   ready_chain;
  logic             accept;
  logic [WIDTH-1:0] xform;

  // ready_chain[k]: stage k can take a word this cycle; walks back from out_ready.
  always_comb begin
    advance            = '0;
    ready_chain        = '0;
    ready_chain[DEPTH] = bus.out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      advance[k]     = stage_valid[k] && ready_chain[k+1];
      ready_chain[k] = !stage_valid[k] || advance[k];
    end
  end

  assign bus.in_ready = ready_chain[0];
  assign accept       = bus.in_valid && ready_chain[0];

  always_comb begin
    xform = bus.in_data;
    case (bus.in_mode)
      2'b00:   xform = bus.in_data;
      2'b01:   xform = ~bus.in_data;
      2'b10:   xform = bus.in_data ^ bus.in_mask;
      default: xform = bus.in_data ^ ~bus.in_mask;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             load;
      logic [WIDTH-1:0] src;
      logic             valid_reg;
      logic [WIDTH-1:0] data_reg;

      if (gi == 0) begin : g_head
        assign load = accept;
        assign src  = xform;
      end else begin : g_body
        assign load = advance[gi-1];
        assign src  = stage_data[gi-1];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else begin
          valid_reg <= load || (valid_reg && !advance[gi]);
          if (load) begin
            data_reg <= src;
          end
        end
      end

      assign stage_valid[gi] = valid_reg;
      assign stage_data[gi]  = data_reg;
    end
  endgenerate

  assign bus.out_valid = stage_valid[DEPTH-1];
  assign bus.out_data  = stage_data[DEPTH-1];

`ifdef NOT_PIPE_XFER_CNT_EN
  logic [15:0] xfer_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_reg <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_reg;
`else
  assign xfer_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_not_pipe.sv
// Directed bench for not_pipe (WIDTH=8, DEPTH=2): latency, modes, backpressure, full pass-through, async reset.
module tb_not_pipe;
  logic        clk;
  logic        rst;
  logic [15:0] xfer_cnt;
  int          tests;
  int          failed;

  not_pipe_if #(.WIDTH(8)) bus ();

  not_pipe #(.WIDTH(8), .DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef NOT_PIPE_XFER_CNT_EN
  localparam logic [15:0] CNT_AFTER_BP   = 16'd7;
  localparam logic [15:0] CNT_AFTER_WRAP = 16'd1;
`else
  localparam logic [15:0] CNT_AFTER_BP   = 16'd0;
  localparam logic [15:0] CNT_AFTER_WRAP = 16'd0;
`endif

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] m, input logic [7:0] k);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_mode  = m;
    bus.in_mask  = k;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    drive(1'b0, 8'h00, 2'b00, 8'h00);
    bus.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_out_data", {8'd0, bus.out_data}, 16'h0000);
    chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
    chk("rst_xfer_cnt", xfer_cnt, 16'h0000);
    step();
    step();
    rst = 1'b0;
    step();

    // single word, invert all: visible after the second edge, for one cycle
    drive(1'b1, 8'hA5, 2'b01, 8'h00);
    step();
    drive(1'b0, 8'h00, 2'b00, 8'h00);
    chk("lat_not_yet", {15'd0, bus.out_valid}, 16'd0);
    step();
    chk("lat_valid", {15'd0, bus.out_valid}, 16'd1);
    chk("lat_data", {8'd0, bus.out_data}, 16'h005A);
    step();
    chk("lat_one_cycle", {15'd0, bus.out_valid}, 16'd0);

    // modes 00/10/11 back to back; mask changed while words are in flight
    drive(1'b1, 8'h3C, 2'b00, 8'h0F);
    step();
    drive(1'b1, 8'h3C, 2'b10, 8'h0F);
    step();
    chk("mode00", {8'd0, bus.out_data}, 16'h003C);
    drive(1'b1, 8'h3C, 2'b11, 8'h0F);
    step();
    drive(1'b0, 8'h3C, 2'b11, 8'hFF);
    chk("mode10", {8'd0, bus.out_data}, 16'h0033);
    step();
    chk("mode11_valid", {15'd0, bus.out_valid}, 16'd1);
    chk("mode11", {8'd0, bus.out_data}, 16'h00CC);
    step();
    chk("mode_drain", {15'd0, bus.out_valid}, 16'd0);

    // backpressure: two accepts fill the pipe, third word waits
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h01, 2'b00, 8'h00);
    step();
    chk("bp_ready_1", {15'd0, bus.in_ready}, 16'd1);
    drive(1'b1, 8'h02, 2'b00, 8'h00);
    step();
    drive(1'b1, 8'h03, 2'b00, 8'h00);
    chk("bp_full_ready", {15'd0, bus.in_ready}, 16'd0);
    step();
    chk("bp_still_full", {15'd0, bus.in_ready}, 16'd0);
    chk("bp_hold_valid", {15'd0, bus.out_valid}, 16'd1);
    chk("bp_hold_data", {8'd0, bus.out_data}, 16'h0001);
    bus.out_ready = 1'b1;
    #1;
    chk("full_ready_comb", {15'd0, bus.in_ready}, 16'd1);
    step();
    drive(1'b0, 8'h00, 2'b00, 8'h00);
    chk("full_sim_ready", {15'd0, bus.in_ready}, 16'd1);
    chk("bp_data_2", {8'd0, bus.out_data}, 16'h0002);
    step();
    chk("bp_valid_3", {15'd0, bus.out_valid}, 16'd1);
    chk("bp_data_3", {8'd0, bus.out_data}, 16'h0003);
    step();
    chk("bp_drain", {15'd0, bus.out_valid}, 16'd0);
    chk("cnt_after_bp", xfer_cnt, CNT_AFTER_BP);

    // asynchronous reset with two words in flight
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h11, 2'b00, 8'h00);
    step();
    drive(1'b1, 8'h22, 2'b00, 8'h00);
    step();
    drive(1'b0, 8'h00, 2'b00, 8'h00);
    chk("pre_rst_valid", {15'd0, bus.out_valid}, 16'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("arst_data", {8'd0, bus.out_data}, 16'h0000);
    chk("arst_ready", {15'd0, bus.in_ready}, 16'd1);
    chk("arst_cnt", xfer_cnt, 16'h0000);
    #2;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("post_rst_1", {15'd0, bus.out_valid}, 16'd0);
    step();
    chk("post_rst_2", {15'd0, bus.out_valid}, 16'd0);
    step();
    chk("post_rst_3", {15'd0, bus.out_valid}, 16'd0);

`ifdef NOT_PIPE_XFER_CNT_EN
    // 65537 transfers wrap the counter to 1
    drive(1'b1, 8'h55, 2'b01, 8'h00);
    for (int i = 0; i < 65537; i++) begin
      step();
    end
    drive(1'b0, 8'h00, 2'b00, 8'h00);
    step();
    chk("wrap_last_data", {8'd0, bus.out_data}, 16'h00AA);
    step();
    chk("wrap_drained", {15'd0, bus.out_valid}, 16'd0);
`endif
    chk("cnt_final", xfer_cnt, CNT_AFTER_WRAP);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
